// File: rtl/vx_amo_req_gate_pkg.sv
// Shared constants and state encoding for the AMO request ordering gate.
package vx_amo_req_gate_pkg;

  localparam int unsigned MEM_REQ_FLAG_AMO = 3;

  typedef logic [0:0] amo_gate_state_t;

  localparam amo_gate_state_t AMO_GATE_IDLE    = 1'b0;
  localparam amo_gate_state_t AMO_GATE_PENDING = 1'b1;

endpackage

// File: rtl/vx_amo_req_fifo.sv
// In-order request queue: DEPTH entries, registered head, no same-cycle bypass.
module vx_amo_req_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  full,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic                  empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push_fire_c;
  logic                  pop_fire_c;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign push_fire_c = push && !full;
  assign pop_fire_c  = pop && !empty;
  assign head_data   = mem[rd_ptr];

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push_fire_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_fire_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_fire_c, pop_fire_c})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vx_amo_req_gate.sv
// Orders requests ahead of the AMO unit: one AMO in flight, same-line followers held
// until its response is seen. Define AMO_GATE_PERF_EN to build the perf counters.
module vx_amo_req_gate
  import vx_amo_req_gate_pkg::*;
#(
  parameter int unsigned TAG_WIDTH      = 8,
  parameter int unsigned WORD_WIDTH     = 32,
  parameter int unsigned WORD_SIZE      = 4,
  parameter int unsigned ADDR_WIDTH     = 30,
  parameter int unsigned LINE_SEL_BITS  = 2,
  parameter int unsigned FLAGS_WIDTH    = 8,
  parameter int unsigned SIDEBAND_WIDTH = 8,
  parameter int unsigned DEPTH          = 4,
  parameter int unsigned PERF_WIDTH     = 32
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      in_req_valid,
  output logic                      in_req_ready,
  input  logic [TAG_WIDTH-1:0]      in_req_tag,
  input  logic [ADDR_WIDTH-1:0]     in_req_addr,
  input  logic                      in_req_rw,
  input  logic [WORD_SIZE-1:0]      in_req_byteen,
  input  logic [WORD_WIDTH-1:0]     in_req_data,
  input  logic [FLAGS_WIDTH-1:0]    in_req_flags,
  input  logic [SIDEBAND_WIDTH-1:0] in_req_sideband,

  output logic                      out_req_valid,
  input  logic                      out_req_ready,
  output logic [TAG_WIDTH-1:0]      out_req_tag,
  output logic [ADDR_WIDTH-1:0]     out_req_addr,
  output logic                      out_req_rw,
  output logic [WORD_SIZE-1:0]      out_req_byteen,
  output logic [WORD_WIDTH-1:0]     out_req_data,
  output logic [FLAGS_WIDTH-1:0]    out_req_flags,
  output logic [SIDEBAND_WIDTH-1:0] out_req_sideband,

  input  logic                      rsp_mon_valid,
  input  logic                      rsp_mon_ready,
  input  logic [TAG_WIDTH-1:0]      rsp_mon_tag,

  output logic                      busy,
  output logic [PERF_WIDTH-1:0]     perf_stall_cycles,
  output logic [PERF_WIDTH-1:0]     perf_amo_count
);

  localparam int unsigned LINE_W = ADDR_WIDTH - LINE_SEL_BITS;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]      tag;
    logic [ADDR_WIDTH-1:0]     addr;
    logic                      rw;
    logic [WORD_SIZE-1:0]      byteen;
    logic [WORD_WIDTH-1:0]     data;
    logic [FLAGS_WIDTH-1:0]    flags;
    logic [SIDEBAND_WIDTH-1:0] sideband;
  } amo_gate_entry_t;

  localparam int unsigned ENTRY_W = $bits(amo_gate_entry_t);

  amo_gate_entry_t  in_entry_c;
  amo_gate_entry_t  head_c;
  logic             full_c;
  logic             empty_c;
  logic [LINE_W-1:0] head_line_c;
  logic             head_is_amo_c;
  logic             blocked_c;
  logic             out_fire_c;
  logic             rsp_hit_c;

  amo_gate_state_t       state_q,    state_d;
  logic [LINE_W-1:0]     amo_line_q, amo_line_d;
  logic [TAG_WIDTH-1:0]  amo_tag_q,  amo_tag_d;

  assign in_entry_c = '{tag:      in_req_tag,
                        addr:     in_req_addr,
                        rw:       in_req_rw,
                        byteen:   in_req_byteen,
                        data:     in_req_data,
                        flags:    in_req_flags,
                        sideband: in_req_sideband};

  vx_amo_req_fifo #(
    .DATA_WIDTH (ENTRY_W),
    .DEPTH      (DEPTH)
  ) fifo_i (
    .clk       (clk),
    .reset     (reset),
    .push      (in_req_valid),
    .push_data (in_entry_c),
    .full      (full_c),
    .pop       (out_fire_c),
    .head_data (head_c),
    .empty     (empty_c)
  );

  assign in_req_ready  = !full_c;
  assign head_line_c   = head_c.addr[ADDR_WIDTH-1:LINE_SEL_BITS];
  assign head_is_amo_c = head_c.flags[MEM_REQ_FLAG_AMO];

  // While an AMO is outstanding, hold any AMO and any access to its line.
  assign blocked_c  = (state_q == AMO_GATE_PENDING) &&
                      (head_is_amo_c || (head_line_c == amo_line_q));
  assign out_req_valid = !empty_c && !blocked_c;
  assign out_fire_c    = out_req_valid && out_req_ready;
  assign rsp_hit_c     = rsp_mon_valid && rsp_mon_ready && (rsp_mon_tag == amo_tag_q);

  assign out_req_tag      = head_c.tag;
  assign out_req_addr     = head_c.addr;
  assign out_req_rw       = head_c.rw;
  assign out_req_byteen   = head_c.byteen;
  assign out_req_data     = head_c.data;
  assign out_req_flags    = head_c.flags;
  assign out_req_sideband = head_c.sideband;

  assign busy = !empty_c || (state_q == AMO_GATE_PENDING);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= AMO_GATE_IDLE;
      amo_line_q <= '0;
      amo_tag_q  <= '0;
    end else begin
      state_q    <= state_d;
      amo_line_q <= amo_line_d;
      amo_tag_q  <= amo_tag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    amo_line_d = amo_line_q;
    amo_tag_d  = amo_tag_q;
    case (state_q)
      AMO_GATE_IDLE: begin
        if (out_fire_c && head_is_amo_c) begin
          state_d    = AMO_GATE_PENDING;
          amo_line_d = head_line_c;
          amo_tag_d  = head_c.tag;
        end
      end
      default: begin
        if (rsp_hit_c) begin
          state_d = AMO_GATE_IDLE;
        end
      end
    endcase
  end

`ifdef AMO_GATE_PERF_EN
  logic [PERF_WIDTH-1:0] stall_cnt_q;
  logic [PERF_WIDTH-1:0] amo_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      amo_cnt_q   <= '0;
    end else begin
      if (!empty_c && blocked_c && (stall_cnt_q != {PERF_WIDTH{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + PERF_WIDTH'(1);
      end
      if (out_fire_c && head_is_amo_c && (amo_cnt_q != {PERF_WIDTH{1'b1}})) begin
        amo_cnt_q <= amo_cnt_q + PERF_WIDTH'(1);
      end
    end
  end

  assign perf_stall_cycles = stall_cnt_q;
  assign perf_amo_count    = amo_cnt_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_amo_count    = '0;
`endif

endmodule
